quad_seq_ctrl: RTL and testbench

- Command-driven sequencer for the quadrature A/B pattern generator.
- Accepts one move command: step count, direction and per-phase dwell time.
- Steps the A/B Gray sequence forward or reverse at the commanded rate and tracks a signed position.
- Used as the stimulus source for encoder-interface bring-up and motor-emulation test rigs.

---
 rtl/quad_pkg.sv | 29 ++
 rtl/quad_seq_ctrl_if.sv | 40 ++++
 rtl/quad_phase_gen.sv | 32 +++
 rtl/quad_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_quad_seq_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature sequencer.
// Holds the phase encoding, the A/B decode and the phase step function.
package quad_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [1:0] phase_t;

    // Gray decode: returns {a, b}.
    function automatic logic [1:0] phase_ab(input phase_t p);
        logic [1:0] ab;
        unique case (p)
            2'd0:    ab = 2'b10;
            2'd1:    ab = 2'b11;
            2'd2:    ab = 2'b01;
            default: ab = 2'b00;
        endcase
        return ab;
    endfunction

    function automatic phase_t next_phase(input phase_t p, input logic dir);
        return dir ? phase_t'(p + 2'd1) : phase_t'(p - 2'd1);
    endfunction

endpackage

// File: rtl/quad_seq_ctrl_if.sv
// Command and output bundle of the quadrature sequencer.
// Port z exists only when QUAD_INDEX_EN is defined.
interface quad_seq_ctrl_if #(
    parameter int STEP_W  = 16,
    parameter int DWELL_W = 16,
    parameter int POS_W   = 32
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_dir;
    logic [STEP_W-1:0]  cmd_steps;
    logic [DWELL_W-1:0] cmd_dwell;
    logic               abort;
    logic               a;
    logic               b;
    logic               busy;
    logic               done;
    logic               aborted;
    logic [POS_W-1:0]   pos;
`ifdef QUAD_INDEX_EN
    logic               z;
`endif

    modport master (
        output cmd_valid, cmd_dir, cmd_steps, cmd_dwell, abort,
        input  cmd_ready, a, b, busy, done, aborted, pos
`ifdef QUAD_INDEX_EN
        , input z
`endif
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_steps, cmd_dwell, abort,
        output cmd_ready, a, b, busy, done, aborted, pos
`ifdef QUAD_INDEX_EN
        , output z
`endif
    );

endinterface

// File: rtl/quad_phase_gen.sv
// Phase register with flop-driven A/B outputs.
// Advances one Gray step per step_en, direction chosen by dir.
module quad_phase_gen
    import quad_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic step_en,
    input  logic dir,
    output logic a,
    output logic b
);

    phase_t phase_q;
    phase_t phase_nxt;

    assign phase_nxt = next_phase(phase_q, dir);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 2'd0;
            a       <= 1'b1;
            b       <= 1'b0;
        end else if (step_en) begin
            phase_q  <= phase_nxt;
            {a, b}   <= phase_ab(phase_nxt);
        end
    end

endmodule

// File: rtl/quad_seq_ctrl.sv
// Command-driven quadrature A/B sequencer with signed position tracking.
// Optional index output z and its counter are enabled by QUAD_INDEX_EN.
module quad_seq_ctrl
    import quad_pkg::*;
#(
    parameter int STEP_W  = 16,
    parameter int DWELL_W = 16,
    parameter int POS_W   = 32
`ifdef QUAD_INDEX_EN
    , parameter int INDEX_PERIOD = 400
`endif
) (
    input  logic           clk,
    input  logic           rst_n,
    quad_seq_ctrl_if.slave bus
);

    state_t             state;
    logic               dir_q;
    logic [STEP_W-1:0]  steps_left;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell_rld;
    logic [POS_W-1:0]   pos_q;
    logic               cmd_ready_q;
    logic               busy_q;
    logic               done_q;
    logic               aborted_q;
    logic               a_w;
    logic               b_w;

    logic               accept;
    logic               step_en;
    logic [DWELL_W-1:0] dwell_m1;

    assign accept   = bus.cmd_valid && cmd_ready_q;
    // A dwell of 0 behaves as 1, so the reload value floors at 0.
    assign dwell_m1 = (bus.cmd_dwell == '0) ? '0 : bus.cmd_dwell - DWELL_W'(1);
    // Abort wins over a coincident step edge.
    assign step_en  = (state == RUN) && !bus.abort && (dwell_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dir_q       <= 1'b0;
            steps_left  <= '0;
            dwell_cnt   <= '0;
            dwell_rld   <= '0;
            pos_q       <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        dir_q       <= bus.cmd_dir;
                        steps_left  <= bus.cmd_steps;
                        dwell_cnt   <= dwell_m1;
                        dwell_rld   <= dwell_m1;
                        aborted_q   <= 1'b0;
                        cmd_ready_q <= 1'b0;
                        if (bus.cmd_steps == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        state     <= DONE;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        aborted_q <= 1'b1;
                    end else if (dwell_cnt == '0) begin
                        pos_q      <= dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                        steps_left <= steps_left - STEP_W'(1);
                        dwell_cnt  <= dwell_rld;
                        if (steps_left == STEP_W'(1)) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt - DWELL_W'(1);
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    quad_phase_gen u_phase (
        .clk     (clk),
        .rst_n   (rst_n),
        .step_en (step_en),
        .dir     (dir_q),
        .a       (a_w),
        .b       (b_w)
    );

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;
    assign bus.pos       = pos_q;
    assign bus.a         = a_w;
    assign bus.b         = b_w;

`ifdef QUAD_INDEX_EN
    localparam int IDX_W = (INDEX_PERIOD > 1) ? $clog2(INDEX_PERIOD) : 1;

    logic [IDX_W-1:0] idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else if (step_en) begin
            if (dir_q)
                idx_q <= (idx_q == IDX_W'(INDEX_PERIOD - 1)) ? '0 : idx_q + IDX_W'(1);
            else
                idx_q <= (idx_q == '0) ? IDX_W'(INDEX_PERIOD - 1) : idx_q - IDX_W'(1);
        end
    end

    // Phase 0 is the only phase decoding to A=1, B=0.
    assign bus.z = (idx_q == '0) && a_w && !b_w;
`endif

endmodule

// File: tb/tb_quad_seq_ctrl.sv
// Self-checking bench for quad_seq_ctrl against an edge-count reference model.
// Define QUAD_INDEX_EN on both bench and RTL to exercise the index output.
module tb_quad_seq_ctrl;

    localparam int STEP_W  = 16;
    localparam int DWELL_W = 16;
    localparam int POS_W   = 8;
    localparam int IDX_P   = 400;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Reference model state, expressed in spec terms.
    int               m_phase = 0;
    int               m_idx   = 0;
    logic [POS_W-1:0] m_pos   = '0;
    logic             m_aborted = 1'b0;
    int               z_rises = 0;
    logic             z_prev  = 1'b1;

    always #5 clk = ~clk;

    quad_seq_ctrl_if #(.STEP_W(STEP_W), .DWELL_W(DWELL_W), .POS_W(POS_W)) qif ();

    quad_seq_ctrl #(
        .STEP_W  (STEP_W),
        .DWELL_W (DWELL_W),
        .POS_W   (POS_W)
`ifdef QUAD_INDEX_EN
        , .INDEX_PERIOD (IDX_P)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (qif.slave)
    );

    function automatic int wrapmod(input int x, input int m);
        return ((x % m) + m) % m;
    endfunction

    // Runs one move starting on a negedge; checks every cycle from the
    // accept edge until the block is ready again. abort_at = cycle index
    // (counted from the accept edge) on whose edge abort is high; 0 = none.
    task automatic run_move(input string name, input logic dir, input int steps,
                            input int dwell, input int abort_at);
        int d = (dwell == 0) ? 1 : dwell;
        int s = dir ? 1 : -1;
        int end_n, k_tot, guard, k, ph;
        logic ab;
        logic [POS_W-1:0] exp_pos;
        logic exp_a, exp_b, exp_busy, exp_done, exp_ready, exp_abd;

        if (steps == 0) begin
            end_n = 0; k_tot = 0; ab = 1'b0;
        end else if (abort_at != 0 && abort_at <= steps * d) begin
            end_n = abort_at; k_tot = (abort_at - 1) / d; ab = 1'b1;
        end else begin
            end_n = steps * d; k_tot = steps; ab = 1'b0;
        end

        qif.cmd_valid = 1'b1;
        qif.cmd_dir   = dir;
        qif.cmd_steps = STEP_W'(steps);
        qif.cmd_dwell = DWELL_W'(dwell);
        guard = 0;
        while (qif.cmd_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 50) begin
            errors++;
            $display("FAIL %s ready_timeout got cmd_ready=%b required 1", name, qif.cmd_ready);
            qif.cmd_valid = 1'b0;
            return;
        end

        @(posedge clk); @(negedge clk);
        // Fields change after accept; they must not affect the move.
        qif.cmd_valid = 1'b0;
        qif.cmd_dir   = 1'($urandom);
        qif.cmd_steps = STEP_W'($urandom);
        qif.cmd_dwell = DWELL_W'($urandom);

        for (int n = 0; n <= end_n + 1; n++) begin
            k         = (n / d < k_tot) ? n / d : k_tot;
            ph        = wrapmod(m_phase + s * k, 4);
            exp_pos   = POS_W'(int'(m_pos) + s * k);
            exp_a     = (ph == 0 || ph == 1);
            exp_b     = (ph == 1 || ph == 2);
            exp_busy  = (steps != 0) && (n < end_n);
            exp_done  = (n == end_n);
            exp_ready = (n > end_n);
            exp_abd   = ab && (n >= end_n);

            checks++;
            if ({qif.a, qif.b} !== {exp_a, exp_b}) begin
                errors++;
                $display("FAIL %s ab n=%0d got %b%b required %b%b", name, n, qif.a, qif.b, exp_a, exp_b);
            end
            checks++;
            if (qif.pos !== exp_pos) begin
                errors++;
                $display("FAIL %s pos n=%0d got %0h required %0h", name, n, qif.pos, exp_pos);
            end
            checks++;
            if ({qif.busy, qif.done, qif.cmd_ready, qif.aborted} !==
                {exp_busy, exp_done, exp_ready, exp_abd}) begin
                errors++;
                $display("FAIL %s ctl n=%0d got busy/done/rdy/abd=%b%b%b%b required %b%b%b%b",
                         name, n, qif.busy, qif.done, qif.cmd_ready, qif.aborted,
                         exp_busy, exp_done, exp_ready, exp_abd);
            end
`ifdef QUAD_INDEX_EN
            begin
                logic exp_z;
                exp_z = (wrapmod(m_idx + s * k, IDX_P) == 0) && (ph == 0);
                checks++;
                if (qif.z !== exp_z) begin
                    errors++;
                    $display("FAIL %s z n=%0d got %b required %b", name, n, qif.z, exp_z);
                end
                if (qif.z === 1'b1 && z_prev !== 1'b1) z_rises++;
                z_prev = qif.z;
            end
`endif
            qif.abort = (abort_at != 0 && n + 1 == abort_at);
            if (n < end_n + 1) begin
                @(posedge clk); @(negedge clk);
            end
        end
        qif.abort = 1'b0;

        m_phase   = wrapmod(m_phase + s * k_tot, 4);
        m_idx     = wrapmod(m_idx + s * k_tot, IDX_P);
        m_pos     = POS_W'(int'(m_pos) + s * k_tot);
        m_aborted = ab;
    endtask

    task automatic model_reset();
        m_phase = 0; m_idx = 0; m_pos = '0; m_aborted = 1'b0;
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if ({qif.a, qif.b, qif.pos, qif.busy, qif.done, qif.aborted, qif.cmd_ready} !==
            {1'b1, 1'b0, {POS_W{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL %s got a=%b b=%b pos=%0h busy=%b done=%b abd=%b rdy=%b required a=1 b=0 pos=0 busy=0 done=0 abd=0 rdy=1",
                     name, qif.a, qif.b, qif.pos, qif.busy, qif.done, qif.aborted, qif.cmd_ready);
        end
    endtask

    task automatic test_reset();
        qif.cmd_valid = 1'b0; qif.cmd_dir = 1'b0; qif.cmd_steps = '0;
        qif.cmd_dwell = '0;   qif.abort = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("reset_release");
        model_reset();
    endtask

    task automatic test_forward();
        run_move("fwd8_dw4", 1'b1, 8, 4, 0);
        checks++;
        if (qif.pos !== POS_W'(8)) begin
            errors++;
            $display("FAIL fwd8_final_pos got %0d required 8", qif.pos);
        end
    endtask

    task automatic test_reverse_fast();
        run_move("rev3_dw0", 1'b0, 3, 0, 0);
        checks++;
        if (qif.pos !== POS_W'(5)) begin
            errors++;
            $display("FAIL rev3_final_pos got %0d required 5", qif.pos);
        end
    endtask

    task automatic test_zero_steps();
        run_move("zero_steps", 1'b1, 0, 7, 0);
    endtask

    task automatic test_abort();
        logic [POS_W-1:0] p0;
        p0 = qif.pos;
        // 5th edge lands on cycle 10 after accept with dwell 2.
        run_move("abort_5th", 1'b1, 100, 2, 10);
        checks++;
        if (qif.pos !== POS_W'(p0 + 4)) begin
            errors++;
            $display("FAIL abort_pos got %0d required %0d", qif.pos, POS_W'(p0 + 4));
        end
    endtask

    task automatic test_abort_idle();
        logic [1:0] ab0;
        logic [POS_W-1:0] p0;
        ab0 = {qif.a, qif.b};
        p0  = qif.pos;
        qif.abort = 1'b1;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        qif.abort = 1'b0;
        checks++;
        if ({qif.a, qif.b, qif.pos, qif.cmd_ready, qif.busy, qif.done, qif.aborted} !==
            {ab0, p0, 1'b1, 1'b0, 1'b0, m_aborted}) begin
            errors++;
            $display("FAIL abort_idle got ab=%b%b pos=%0h rdy=%b busy=%b done=%b abd=%b required ab=%b pos=%0h rdy=1 busy=0 done=0 abd=%b",
                     qif.a, qif.b, qif.pos, qif.cmd_ready, qif.busy, qif.done, qif.aborted, ab0, p0, m_aborted);
        end
    endtask

    task automatic test_back_to_back();
        run_move("b2b_1", 1'b1, 2, 1, 0);
        run_move("b2b_2", 1'b0, 3, 2, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            logic dir;
            int steps, dwell, d, abort_at;
            dir   = 1'($urandom);
            steps = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
            dwell = $urandom_range(0, 4);
            d     = (dwell == 0) ? 1 : dwell;
            abort_at = 0;
            if (steps > 0 && $urandom_range(0, 3) == 0)
                abort_at = $urandom_range(1, steps * d);
            run_move($sformatf("rand%0d", i), dir, steps, dwell, abort_at);
        end
    endtask

    task automatic test_wrap();
        int to_max;
        to_max = int'(POS_W'(8'h7F - m_pos));
        if (to_max != 0) run_move("wrap_preload", 1'b1, to_max, 1, 0);
        checks++;
        if (qif.pos !== 8'h7F) begin
            errors++;
            $display("FAIL wrap_preload got %0h required 7f", qif.pos);
        end
        run_move("wrap_step", 1'b1, 1, 1, 0);
        checks++;
        if (qif.pos !== 8'h80) begin
            errors++;
            $display("FAIL wrap_step got %0h required 80", qif.pos);
        end
    endtask

    task automatic test_mid_reset();
        qif.cmd_valid = 1'b1; qif.cmd_dir = 1'b1;
        qif.cmd_steps = STEP_W'(50); qif.cmd_dwell = DWELL_W'(3);
        @(posedge clk); @(negedge clk);
        qif.cmd_valid = 1'b0;
        repeat (7) begin @(posedge clk); @(negedge clk); end
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset_async");
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if (qif.done !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_done got %b required 0", qif.done);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

`ifdef QUAD_INDEX_EN
    task automatic test_index();
        test_reset();
        z_rises = 0;
        z_prev  = 1'b1;
        run_move("index_800", 1'b1, 800, 1, 0);
        checks++;
        if (z_rises !== 2 || qif.z !== 1'b1) begin
            errors++;
            $display("FAIL index_windows got rises=%0d z=%b required rises=2 z=1", z_rises, qif.z);
        end
        run_move("index_rev1", 1'b0, 1, 1, 0);
        checks++;
        if (qif.z !== 1'b0) begin
            errors++;
            $display("FAIL index_rev1_z got %b required 0", qif.z);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_forward();
        test_reverse_fast();
        test_zero_steps();
        test_abort();
        test_abort_idle();
        test_back_to_back();
        test_random();
        test_wrap();
        test_mid_reset();
`ifdef QUAD_INDEX_EN
        test_index();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
